// File: rtl/cext_instr_aligner.sv
// Turns the I-cache word stream into whole RVC/RV32 instructions tagged with their PC.
// Keeps one carried halfword so compressed pairs and word-straddling 32-bit instructions are realigned.
module cext_instr_aligner #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            word_valid_i,
  input  logic [XLEN-1:0] word_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            id_stall_i,
  output logic [XLEN-1:0] fetch_addr_o,
  output logic            word_accept_o,
  output logic            fetch_hold_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            is_comp_o,
  output logic            instr_valid_o
);

  typedef enum logic [1:0] {EMPTY, HOLD_C, SPLIT} state_e;

  state_e          state_q, state_d;
  logic [15:0]     buf_q, buf_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic            skip_lo_q, skip_lo_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            is_comp_q, is_comp_d;
  logic            instr_valid_q, instr_valid_d;
  logic            accept;

  logic [15:0]     lo, hi;
  logic            lo_comp, hi_comp;
  logic [XLEN-1:0] fa_plus2, fa_plus4;

  assign lo       = word_data_i[15:0];
  assign hi       = word_data_i[31:16];
  assign lo_comp  = (lo[1:0] != 2'b11);
  assign hi_comp  = (hi[1:0] != 2'b11);
  assign fa_plus2 = fetch_addr_q + XLEN'(2);
  assign fa_plus4 = fetch_addr_q + XLEN'(4);

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    buf_pc_d      = buf_pc_q;
    fetch_addr_d  = fetch_addr_q;
    skip_lo_d     = skip_lo_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    is_comp_d     = is_comp_q;
    instr_valid_d = instr_valid_q;
    accept        = 1'b0;

    if (redirect_i) begin
      state_d       = EMPTY;
      buf_d         = '0;
      buf_pc_d      = '0;
      fetch_addr_d  = {redirect_pc_i[XLEN-1:2], 2'b00};
      skip_lo_d     = redirect_pc_i[1];
      instr_valid_d = 1'b0;
    end else if (!id_stall_i) begin
      instr_valid_d = 1'b0;
      unique case (state_q)
        EMPTY: begin
          if (word_valid_i) begin
            accept       = 1'b1;
            fetch_addr_d = fa_plus4;
            skip_lo_d    = 1'b0;
            if (skip_lo_q) begin
              // Entered mid-word: low half belongs to code before the target
              if (hi_comp) begin
                instr_d       = XLEN'(hi);
                instr_pc_d    = fa_plus2;
                is_comp_d     = 1'b1;
                instr_valid_d = 1'b1;
              end else begin
                buf_d    = hi;
                buf_pc_d = fa_plus2;
                state_d  = SPLIT;
              end
            end else if (lo_comp) begin
              instr_d       = XLEN'(lo);
              instr_pc_d    = fetch_addr_q;
              is_comp_d     = 1'b1;
              instr_valid_d = 1'b1;
              buf_d         = hi;
              buf_pc_d      = fa_plus2;
              state_d       = hi_comp ? HOLD_C : SPLIT;
            end else begin
              instr_d       = word_data_i;
              instr_pc_d    = fetch_addr_q;
              is_comp_d     = 1'b0;
              instr_valid_d = 1'b1;
            end
          end
        end
        HOLD_C: begin
          instr_d       = XLEN'(buf_q);
          instr_pc_d    = buf_pc_q;
          is_comp_d     = 1'b1;
          instr_valid_d = 1'b1;
          state_d       = EMPTY;
        end
        SPLIT: begin
          if (word_valid_i) begin
            accept        = 1'b1;
            fetch_addr_d  = fa_plus4;
            instr_d       = XLEN'({lo, buf_q});
            instr_pc_d    = buf_pc_q;
            is_comp_d     = 1'b0;
            instr_valid_d = 1'b1;
            buf_d         = hi;
            buf_pc_d      = fa_plus2;
            state_d       = hi_comp ? HOLD_C : SPLIT;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= EMPTY;
      buf_q         <= '0;
      buf_pc_q      <= '0;
      fetch_addr_q  <= {RESET_PC[XLEN-1:2], 2'b00};
      skip_lo_q     <= RESET_PC[1];
      instr_q       <= '0;
      instr_pc_q    <= '0;
      is_comp_q     <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      buf_pc_q      <= buf_pc_d;
      fetch_addr_q  <= fetch_addr_d;
      skip_lo_q     <= skip_lo_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      is_comp_q     <= is_comp_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign fetch_addr_o  = fetch_addr_q;
  assign word_accept_o = accept;
  assign fetch_hold_o  = id_stall_i | (state_q == HOLD_C);
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign is_comp_o     = is_comp_q;
  assign instr_valid_o = instr_valid_q;

endmodule

// File: tb/tb_cext_instr_aligner.sv
// Directed table-driven bench for cext_instr_aligner plus a hand-written async-reset sequence.
module tb_cext_instr_aligner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        word_valid_i = 1'b0;
  logic [31:0] word_data_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        id_stall_i = 1'b0;
  logic [31:0] fetch_addr_o;
  logic        word_accept_o;
  logic        fetch_hold_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        is_comp_o;
  logic        instr_valid_o;

  int checks = 0;
  int errors = 0;

  cext_instr_aligner #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .word_valid_i(word_valid_i), .word_data_i(word_data_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_stall_i(id_stall_i),
    .fetch_addr_o(fetch_addr_o), .word_accept_o(word_accept_o),
    .fetch_hold_o(fetch_hold_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .is_comp_o(is_comp_o), .instr_valid_o(instr_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic [31:0] wd;
    logic        rd;
    logic [31:0] rpc;
    logic        st;
    logic        e_acc;
    logic        e_hold;
    logic [31:0] e_fa;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_comp;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic wv, input logic [31:0] wd, input logic rd, input logic [31:0] rpc,
                     input logic st, input logic e_acc, input logic e_hold, input logic [31:0] e_fa,
                     input logic e_vld, input logic [31:0] e_instr, input logic [31:0] e_pc,
                     input logic e_comp);
    vec_t v;
    v = '{wv, wd, rd, rpc, st, e_acc, e_hold, e_fa, e_vld, e_instr, e_pc, e_comp};
    vq.push_back(v);
  endtask

  // Inputs driven at negedge; combinational outputs checked before the edge, registered ones after.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    word_valid_i  = v.wv;
    word_data_i   = v.wd;
    redirect_i    = v.rd;
    redirect_pc_i = v.rpc;
    id_stall_i    = v.st;
    #1;
    chk({tag, " word_accept"}, 32'(word_accept_o), 32'(v.e_acc));
    chk({tag, " fetch_hold"}, 32'(fetch_hold_o), 32'(v.e_hold));
    chk({tag, " fetch_addr"}, fetch_addr_o, v.e_fa);
    @(posedge clk);
    #1;
    chk({tag, " instr_valid"}, 32'(instr_valid_o), 32'(v.e_vld));
    if (v.e_vld) begin
      chk({tag, " instr"}, instr_o, v.e_instr);
      chk({tag, " instr_pc"}, instr_pc_o, v.e_pc);
      chk({tag, " is_comp"}, 32'(is_comp_o), 32'(v.e_comp));
    end
  endtask

  initial begin
    // Basic sequence from reset
    add(1, 32'h00B5_0513, 0, 0, 0,  1, 0, 32'h0,   1, 32'h00B5_0513, 32'h0, 0);
    add(1, 32'h4501_4505, 0, 0, 0,  1, 0, 32'h4,   1, 32'h0000_4505, 32'h4, 1);
    add(1, 32'hDEAD_BEEF, 0, 0, 0,  0, 1, 32'h8,   1, 32'h0000_4501, 32'h6, 1);
    add(0, 32'h0,         0, 0, 0,  0, 0, 32'h8,   0, 32'h0, 32'h0, 0);
    // Straddling 32-bit instruction
    add(0, 32'h0,         1, 32'h0, 0, 0, 0, 32'h8, 0, 32'h0, 32'h0, 0);
    add(1, 32'h0513_4505, 0, 0, 0,  1, 0, 32'h0,   1, 32'h0000_4505, 32'h0, 1);
    add(1, 32'h1234_00B5, 0, 0, 0,  1, 0, 32'h4,   1, 32'h00B5_0513, 32'h2, 0);
    add(0, 32'h0,         0, 0, 0,  0, 1, 32'h8,   1, 32'h0000_1234, 32'h6, 1);
    // Redirect to odd halfword with a word arriving in the same cycle
    add(1, 32'hAAAA_BBBB, 1, 32'h102, 0, 0, 0, 32'h8, 0, 32'h0, 32'h0, 0);
    add(1, 32'h4505_0000, 0, 0, 0,  1, 0, 32'h100, 1, 32'h0000_4505, 32'h102, 1);
    // Stall while in SPLIT
    add(1, 32'h0513_4505, 0, 0, 0,  1, 0, 32'h104, 1, 32'h0000_4505, 32'h104, 1);
    for (int i = 0; i < 3; i++)
      add(1, 32'h4501_00B5, 0, 0, 1, 0, 1, 32'h108, 1, 32'h0000_4505, 32'h104, 1);
    add(1, 32'h4501_00B5, 0, 0, 0,  1, 0, 32'h108, 1, 32'h00B5_0513, 32'h106, 0);
    // Redirect in HOLD_C drops the buffered compressed instruction
    add(0, 32'h0,         1, 32'h200, 0, 0, 1, 32'h10C, 0, 32'h0, 32'h0, 0);
    add(0, 32'h0,         0, 0, 0,  0, 0, 32'h200, 0, 32'h0, 32'h0, 0);
    // Redirect in SPLIT drops the buffered low half
    add(1, 32'h0513_4505, 0, 0, 0,  1, 0, 32'h200, 1, 32'h0000_4505, 32'h200, 1);
    add(1, 32'h1111_2222, 1, 32'h300, 0, 0, 0, 32'h204, 0, 32'h0, 32'h0, 0);
    add(1, 32'h0000_0013, 0, 0, 0,  1, 0, 32'h300, 1, 32'h0000_0013, 32'h300, 0);
    // Odd target whose high half starts a 32-bit instruction
    add(0, 32'h0,         1, 32'h402, 0, 0, 0, 32'h304, 0, 32'h0, 32'h0, 0);
    add(1, 32'h0513_7777, 0, 0, 0,  1, 0, 32'h400, 0, 32'h0, 32'h0, 0);
    add(1, 32'h0000_00B5, 0, 0, 0,  1, 0, 32'h404, 1, 32'h00B5_0513, 32'h402, 0);
    add(0, 32'h0,         0, 0, 0,  0, 1, 32'h408, 1, 32'h0000_0000, 32'h406, 1);
    // Address wrap at the top of the space
    add(0, 32'h0,         1, 32'hFFFF_FFFC, 0, 0, 0, 32'h408, 0, 32'h0, 32'h0, 0);
    add(1, 32'h00B5_0513, 0, 0, 0,  1, 0, 32'hFFFF_FFFC, 1, 32'h00B5_0513, 32'hFFFF_FFFC, 0);
    add(0, 32'h0,         0, 0, 0,  0, 0, 32'h0,   0, 32'h0, 32'h0, 0);

    #12;
    chk("reset instr_valid", 32'(instr_valid_o), 32'h0);
    chk("reset instr", instr_o, 32'h0);
    chk("reset instr_pc", instr_pc_o, 32'h0);
    chk("reset fetch_addr", fetch_addr_o, 32'h0);
    chk("reset fetch_hold", 32'(fetch_hold_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++)
      apply(vq[i], $sformatf("v%0d", i));

    // Async reset mid-SPLIT, checked before any clock edge
    apply('{0, 32'h0, 1, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0}, "ar_redir");
    apply('{1, 32'h0513_4505, 0, 32'h0, 0, 1, 0, 32'h0, 1, 32'h0000_4505, 32'h0, 1}, "ar_fill");
    @(negedge clk);
    word_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset instr_valid", 32'(instr_valid_o), 32'h0);
    chk("areset instr", instr_o, 32'h0);
    chk("areset instr_pc", instr_pc_o, 32'h0);
    chk("areset is_comp", 32'(is_comp_o), 32'h0);
    chk("areset fetch_addr", fetch_addr_o, 32'h0);
    chk("areset fetch_hold", 32'(fetch_hold_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // Buffer must be gone: a full word is emitted intact
    apply('{1, 32'h00B5_0513, 0, 32'h0, 0, 1, 0, 32'h0, 1, 32'h00B5_0513, 32'h0, 0}, "ar_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
